// File: rtl/dec_pkg.sv
// Shared types and helpers for the SECDED syndrome correction stage.
// The optional statistics counters are enabled with the DEC_CORR_STATS_EN macro.
package dec_pkg;

    localparam int unsigned CW_W   = 32;
    localparam int unsigned SYN_W  = 6;
    localparam int unsigned DATA_W = 26;

    typedef logic [CW_W-1:0]   codeword_t;
    typedef logic [SYN_W-1:0]  syndrome_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_DOUBLE
    } err_class_e;

    // Gather the non-power-of-two positions 3..31 in ascending order.
    function automatic data_t extract_data(input codeword_t cw);
        data_t       d;
        int unsigned k;
        d = '0;
        k = 0;
        for (int unsigned p = 1; p < CW_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k[4:0]] = cw[p[4:0]];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/dec_syndrome_corrector_if.sv
// Upstream/downstream valid-ready bundle of the syndrome corrector.
// Counter signals exist only when DEC_CORR_STATS_EN is defined.
interface dec_syndrome_corrector_if
    import dec_pkg::*;
`ifdef DEC_CORR_STATS_EN
    #(parameter int unsigned CNT_W = 16)
`endif
    ();

    logic      in_valid;
    logic      in_ready;
    codeword_t codeword_with_errors;
    syndrome_t mul_result;

    logic      out_valid;
    logic      out_ready;
    codeword_t corrected_codeword;
    data_t     data_out;
    logic      err_single;
    logic      err_double;

`ifdef DEC_CORR_STATS_EN
    logic [CNT_W-1:0] cnt_single;
    logic [CNT_W-1:0] cnt_double;

    modport slave (
        input  in_valid, codeword_with_errors, mul_result, out_ready,
        output in_ready, out_valid, corrected_codeword, data_out, err_single, err_double,
        output cnt_single, cnt_double
    );

    modport master (
        output in_valid, codeword_with_errors, mul_result, out_ready,
        input  in_ready, out_valid, corrected_codeword, data_out, err_single, err_double,
        input  cnt_single, cnt_double
    );
`else
    modport slave (
        input  in_valid, codeword_with_errors, mul_result, out_ready,
        output in_ready, out_valid, corrected_codeword, data_out, err_single, err_double
    );

    modport master (
        output in_valid, codeword_with_errors, mul_result, out_ready,
        input  in_ready, out_valid, corrected_codeword, data_out, err_single, err_double
    );
`endif

endinterface

// File: rtl/dec_err_locator.sv
// Combinational syndrome classifier producing the error class and single-bit flip mask.
module dec_err_locator
    import dec_pkg::*;
(
    input  syndrome_t  i_syndrome,
    output err_class_e o_class,
    output codeword_t  o_mask
);

    // Overall parity set means an odd error count: flip the Hamming-located bit.
    always_comb begin
        o_class = ERR_NONE;
        o_mask  = '0;
        if (i_syndrome == '0) begin
            o_class = ERR_NONE;
        end else if (i_syndrome[SYN_W-1]) begin
            o_class = ERR_SINGLE;
            o_mask  = CW_W'(1) << i_syndrome[4:0];
        end else begin
            o_class = ERR_DOUBLE;
        end
    end

endmodule

// File: rtl/dec_syndrome_corrector.sv
// Two-stage registered SECDED correction pipeline with valid/ready on both sides.
// Define DEC_CORR_STATS_EN to add saturating single/double error counters.
module dec_syndrome_corrector
    import dec_pkg::*;
`ifdef DEC_CORR_STATS_EN
    #(parameter int unsigned CNT_W = 16)
`endif
(
    input logic                     clk,
    input logic                     rst,
    dec_syndrome_corrector_if.slave bus
);

    logic       w_s1_adv;
    logic       w_s2_adv;
    err_class_e w_class;
    codeword_t  w_mask;
    codeword_t  w_s1_fixed;

    logic       r_s1_valid;
    codeword_t  r_s1_cw;
    err_class_e r_s1_class;
    codeword_t  r_s1_mask;

    logic       r_s2_valid;
    codeword_t  r_s2_cw;
    data_t      r_s2_data;
    logic       r_s2_single;
    logic       r_s2_double;

    dec_err_locator u_err_locator (
        .i_syndrome (bus.mul_result),
        .o_class    (w_class),
        .o_mask     (w_mask)
    );

    // A stage advances when it is empty or its successor advances.
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    // Stage 1: capture codeword with its classification and flip mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_class <= ERR_NONE;
            r_s1_mask  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_cw    <= bus.codeword_with_errors;
                r_s1_class <= w_class;
                r_s1_mask  <= w_mask;
            end
        end
    end

    // Mask is zero for clean and double-error words, so no flip happens there.
    assign w_s1_fixed = r_s1_cw ^ r_s1_mask;

    // Stage 2: corrected codeword, extracted data and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_cw     <= '0;
            r_s2_data   <= '0;
            r_s2_single <= 1'b0;
            r_s2_double <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_cw     <= w_s1_fixed;
                r_s2_data   <= extract_data(w_s1_fixed);
                r_s2_single <= (r_s1_class == ERR_SINGLE);
                r_s2_double <= (r_s1_class == ERR_DOUBLE);
            end
        end
    end

    assign bus.out_valid          = r_s2_valid;
    assign bus.corrected_codeword = r_s2_cw;
    assign bus.data_out           = r_s2_data;
    assign bus.err_single         = r_s2_single;
    assign bus.err_double         = r_s2_double;

`ifdef DEC_CORR_STATS_EN
    logic             w_drain;
    logic [CNT_W-1:0] r_cnt_single;
    logic [CNT_W-1:0] r_cnt_double;

    assign w_drain = r_s2_valid && bus.out_ready;

    // Saturating counts of words leaving stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (w_drain) begin
            if (r_s2_single && (r_cnt_single != '1)) begin
                r_cnt_single <= r_cnt_single + CNT_W'(1);
            end
            if (r_s2_double && (r_cnt_double != '1)) begin
                r_cnt_double <= r_cnt_double + CNT_W'(1);
            end
        end
    end

    assign bus.cnt_single = r_cnt_single;
    assign bus.cnt_double = r_cnt_double;
`endif

endmodule

// File: tb/tb_dec_syndrome_corrector.sv
// Self-checking bench: directed vector table, backpressure/reset sequences and
// randomized traffic against a queue-based reference model.
module tb_dec_syndrome_corrector;
    import dec_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef DEC_CORR_STATS_EN
    dec_syndrome_corrector_if #(.CNT_W(CNT_W)) u_if ();
    dec_syndrome_corrector #(.CNT_W(CNT_W)) u_dut (.clk(clk), .rst(rst), .bus(u_if));
`else
    dec_syndrome_corrector_if u_if ();
    dec_syndrome_corrector u_dut (.clk(clk), .rst(rst), .bus(u_if));
`endif

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        codeword_t cw;
        data_t     data;
        logic      single;
        logic      dbl;
    } exp_t;

    // Reference: classify from the syndrome rules, data = non-parity positions in order.
    function automatic exp_t ref_model(input codeword_t cw, input syndrome_t s);
        exp_t        e;
        int unsigned n;
        e.cw     = cw;
        e.single = 1'b0;
        e.dbl    = 1'b0;
        if (s[5]) begin
            e.cw[s[4:0]] = ~cw[s[4:0]];
            e.single     = 1'b1;
        end else if (s != 6'd0) begin
            e.dbl = 1'b1;
        end
        e.data = '0;
        n      = 0;
        for (int p = 0; p < 32; p++) begin
            if (p != 0 && $countones(p) != 1) begin
                e.data[n] = e.cw[p];
                n++;
            end
        end
        return e;
    endfunction

    exp_t        sb[$];
    int unsigned m_single;
    int unsigned m_double;

    // Scoreboard: record accepted inputs, compare drained outputs in order.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_single = 0;
            m_double = 0;
        end else begin
`ifdef DEC_CORR_STATS_EN
            check("cnt_single", 32'(u_if.cnt_single), 32'(m_single));
            check("cnt_double", 32'(u_if.cnt_double), 32'(m_double));
`endif
            if (u_if.in_valid && u_if.in_ready)
                sb.push_back(ref_model(u_if.codeword_with_errors, u_if.mul_result));
            if (u_if.out_valid && u_if.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_output", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_cw",     u_if.corrected_codeword, e.cw);
                    check("sb_data",   32'(u_if.data_out),      32'(e.data));
                    check("sb_single", 32'(u_if.err_single),    32'(e.single));
                    check("sb_double", 32'(u_if.err_double),    32'(e.dbl));
                    if (e.single && m_single != (2**CNT_W - 1)) m_single++;
                    if (e.dbl && m_double != (2**CNT_W - 1)) m_double++;
                end
            end
        end
    end

    typedef struct {
        codeword_t cw;
        syndrome_t s;
        codeword_t exp_cw;
        data_t     exp_data;
        logic      exp_single;
        logic      exp_double;
    } vec_t;

    vec_t tbl[7];

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'(0));
    endtask

    initial begin
        logic acc;

        tbl[0] = '{32'h0000_0000, 6'b000000, 32'h0000_0000, 26'h000_0000, 1'b0, 1'b0};
        tbl[1] = '{32'h0000_0000, 6'b100101, 32'h0000_0020, 26'h000_0002, 1'b1, 1'b0};
        tbl[2] = '{32'h0000_0000, 6'b100000, 32'h0000_0001, 26'h000_0000, 1'b1, 1'b0};
        tbl[3] = '{32'hAAAA_AAAA, 6'b000011, 32'hAAAA_AAAA, 26'h2AA_AD5B, 1'b0, 1'b1};
        tbl[4] = '{32'h0000_0000, 6'b111111, 32'h8000_0000, 26'h200_0000, 1'b1, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF, 6'b100011, 32'hFFFF_FFF7, 26'h3FF_FFFE, 1'b1, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 6'b000000, 32'hFFFF_FFFF, 26'h3FF_FFFF, 1'b0, 1'b0};

        rst                       = 1'b1;
        u_if.in_valid             = 1'b0;
        u_if.codeword_with_errors = '0;
        u_if.mul_result           = '0;
        u_if.out_ready            = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(u_if.out_valid), 32'(0));
        check("rst_in_ready",  32'(u_if.in_ready),  32'(1));
        check("rst_cw",        u_if.corrected_codeword, 32'(0));
        check("rst_data",      32'(u_if.data_out), 32'(0));
        check("rst_flags",     32'({u_if.err_single, u_if.err_double}), 32'(0));

        // Directed vectors, one at a time, checking the 2-cycle latency.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            u_if.in_valid             = 1'b1;
            u_if.codeword_with_errors = tbl[i].cw;
            u_if.mul_result           = tbl[i].s;
            @(negedge clk);
            check("vec_in_ready", 32'(u_if.in_ready), 32'(1));
            @(posedge clk); #1;
            u_if.in_valid = 1'b0;
            @(negedge clk);
            check("vec_lat1_valid", 32'(u_if.out_valid), 32'(0));
            @(negedge clk);
            check("vec_lat2_valid", 32'(u_if.out_valid), 32'(1));
            check("vec_cw",     u_if.corrected_codeword, tbl[i].exp_cw);
            check("vec_data",   32'(u_if.data_out),   32'(tbl[i].exp_data));
            check("vec_single", 32'(u_if.err_single), 32'(tbl[i].exp_single));
            check("vec_double", 32'(u_if.err_double), 32'(tbl[i].exp_double));
        end
        drain("vec_drain");

        // Backpressure: three back-to-back words with the consumer stalled.
        @(posedge clk); #1;
        u_if.out_ready            = 1'b0;
        u_if.in_valid             = 1'b1;
        u_if.codeword_with_errors = 32'h0000_0001;
        u_if.mul_result           = 6'b000000;
        @(negedge clk);
        check("bp_ready0", 32'(u_if.in_ready), 32'(1));
        @(posedge clk); #1;
        u_if.codeword_with_errors = 32'h0000_0000;
        u_if.mul_result           = 6'b100101;
        @(negedge clk);
        check("bp_ready1", 32'(u_if.in_ready), 32'(1));
        @(posedge clk); #1;
        u_if.codeword_with_errors = 32'hAAAA_AAAA;
        u_if.mul_result           = 6'b000011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_full_ready", 32'(u_if.in_ready),  32'(0));
            check("bp_hold_valid", 32'(u_if.out_valid), 32'(1));
            check("bp_hold_cw",    u_if.corrected_codeword, 32'h0000_0001);
            @(posedge clk); #1;
        end
        u_if.out_ready = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                acc = u_if.in_ready;
                n++;
            end while (!acc && n < 10);
            check("bp_release", 32'(acc), 32'(1));
        end
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        drain("bp_drain");

        // Randomized traffic with random stalls on both sides.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc = u_if.in_valid && u_if.in_ready;
            @(posedge clk); #1;
            if (!u_if.in_valid || acc) begin
                u_if.in_valid             = ($urandom_range(0, 3) != 0);
                u_if.codeword_with_errors = $urandom;
                case ($urandom_range(0, 3))
                    0: u_if.mul_result = 6'd0;
                    1: u_if.mul_result = {1'b1, 5'($urandom)};
                    2: u_if.mul_result = {1'b0, 5'($urandom_range(1, 31))};
                    default: u_if.mul_result = 6'($urandom);
                endcase
            end
            u_if.out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        drain("rand_drain");

`ifdef DEC_CORR_STATS_EN
        // Counter saturation: 17 single-error words from a fresh reset.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            u_if.in_valid             = 1'b1;
            u_if.codeword_with_errors = $urandom;
            u_if.mul_result           = {1'b1, 5'(i)};
            @(posedge clk); #1;
        end
        u_if.in_valid = 1'b0;
        drain("sat_drain");
        @(negedge clk);
        check("cnt_single_sat", 32'(u_if.cnt_single), 32'hF);
        check("cnt_double_zero", 32'(u_if.cnt_double), 32'h0);
`endif

        // Reset with words in flight drops them.
        @(posedge clk); #1;
        u_if.in_valid             = 1'b1;
        u_if.codeword_with_errors = 32'h1234_5678;
        u_if.mul_result           = 6'b100001;
        @(posedge clk); #1;
        u_if.mul_result = 6'b000111;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(u_if.out_valid), 32'(0));
        check("mid_rst_ready", 32'(u_if.in_ready),  32'(1));
        check("mid_rst_flags", 32'({u_if.err_single, u_if.err_double}), 32'(0));
`ifdef DEC_CORR_STATS_EN
        check("mid_rst_cnt", 32'({u_if.cnt_single, u_if.cnt_double}), 32'(0));
`endif
        repeat (3) @(negedge clk);
        check("mid_rst_quiet", 32'(u_if.out_valid), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
